// File: rtl/vga_attr_regbank_pkg.sv
// vga_attr_pkg: STATUS field positions, register-map offsets and the
// byte-enable merge shared by the VGA attribute register bank.
package vga_attr_pkg;

  localparam int ST_VS_TOGGLE     = 0;
  localparam int ST_COMMIT_PEND   = 1;
  localparam int ST_FRAME_CNT_LSB = 16;

  // Control word sits right after the palette.
  function automatic int ctrl_addr(input int pal_depth);
    return pal_depth;
  endfunction

  function automatic int status_addr(input int pal_depth);
    return pal_depth + 1;
  endfunction

  function automatic int attr_base(input int pal_depth);
    return pal_depth + 2;
  endfunction

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/vga_attr_regbank_vs_edge.sv
// vga_vs_edge: vsync rising-edge detector, frame tick pulse, VS toggle bit
// and wrapping frame counter.
module vga_vs_edge #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vs_i,
  output logic             rise_o,
  output logic             frame_tick_o,
  output logic             vs_toggle_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  logic             vs_q, tick_q, tog_q;
  logic [CNT_W-1:0] cnt_q;

  assign rise_o       = vs_i & ~vs_q;
  assign frame_tick_o = tick_q;
  assign vs_toggle_o  = tog_q;
  assign frame_cnt_o  = cnt_q;

  // Edge history plus per-frame bookkeeping, all updated on the detected rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q   <= 1'b0;
      tick_q <= 1'b0;
      tog_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vs_q   <= vs_i;
      tick_q <= rise_o;
      if (rise_o) begin
        tog_q <= ~tog_q;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_attr_regbank.sv
// vga_attr_regbank: Avalon-MM palette/control/attribute register bank.
// With VGA_ATTR_SHADOW_EN defined, writes land in shadow words and are
// copied to the live words on the first vsync rise after software arms
// COMMIT_PEND. Without it, writes go straight to the live words.
module vga_attr_regbank
  import vga_attr_pkg::*;
#(
  parameter int PAL_DEPTH  = 8,
  parameter int ATTR_DEPTH = 32,
  parameter int ADDR_W     = 11,
  parameter int CNT_W      = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    AVL_CS,
  input  logic                    AVL_READ,
  input  logic                    AVL_WRITE,
  input  logic [ADDR_W-1:0]       AVL_ADDR,
  input  logic [3:0]              AVL_BYTE_EN,
  input  logic [31:0]             AVL_WRITEDATA,
  output logic [31:0]             AVL_READDATA,
  input  logic                    vs,
  output logic [PAL_DEPTH*32-1:0] pal_live,
  output logic [31:0]             ctrl_live,
  output logic [ATTR_DEPTH*32-1:0] attr_live,
  output logic                    frame_tick
);

  // Data words are packed densely: palette, control, then attributes.
  localparam int NW     = PAL_DEPTH + 1 + ATTR_DEPTH;
  localparam int IDX_W  = $clog2(NW);
  localparam int CTRL_A = ctrl_addr(PAL_DEPTH);
  localparam int ST_A   = status_addr(PAL_DEPTH);
  localparam int ATTR_A = attr_base(PAL_DEPTH);

  logic             rise, vs_tog;
  logic [CNT_W-1:0] frame_cnt;
  logic             wr, rd, hit, is_st, pend;
  logic [IDX_W-1:0] widx;
  logic [31:0]      addr_w, rd_word, status_w, rdata_d, rdata_q;
  logic [31:0]      live_q [NW];

  vga_vs_edge #(.CNT_W(CNT_W)) u_vs_edge (
    .clk_i        (CLK),
    .rst_ni       (RESET),
    .vs_i         (vs),
    .rise_o       (rise),
    .frame_tick_o (frame_tick),
    .vs_toggle_o  (vs_tog),
    .frame_cnt_o  (frame_cnt)
  );

  // A read in the same cycle as a write takes priority; the write is dropped.
  assign wr = AVL_CS & AVL_WRITE & ~AVL_READ;
  assign rd = AVL_CS & AVL_READ;

  // Address decode to a dense data-word index, STATUS, or unmapped.
  always_comb begin
    addr_w = 32'(AVL_ADDR);
    hit    = 1'b0;
    is_st  = 1'b0;
    widx   = '0;
    if (addr_w <= 32'(CTRL_A)) begin
      hit  = 1'b1;
      widx = IDX_W'(addr_w);
    end else if (addr_w == 32'(ST_A)) begin
      is_st = 1'b1;
    end else if (addr_w >= 32'(ATTR_A) && addr_w < 32'(ATTR_A + ATTR_DEPTH)) begin
      hit  = 1'b1;
      widx = IDX_W'(addr_w - 32'd1);
    end
  end

`ifdef VGA_ATTR_SHADOW_EN
  logic [31:0] sh_q [NW];
  logic        pend_q, pend_d;

  // Shadow words take byte-masked writes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NW; i++) sh_q[i] <= '0;
    end else if (wr && hit) begin
      sh_q[widx] <= be_merge(sh_q[widx], AVL_WRITEDATA, AVL_BYTE_EN);
    end
  end

  // Atomic frame commit: live copies the pre-write shadow on an armed rise.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NW; i++) live_q[i] <= '0;
    end else if (rise && pend_q) begin
      live_q <= sh_q;
    end
  end

  // Arming beats the clear, so an arm coinciding with a rise waits a frame.
  always_comb begin
    pend_d = pend_q;
    if (rise && pend_q) pend_d = 1'b0;
    if (wr && is_st && AVL_BYTE_EN[0] && AVL_WRITEDATA[ST_COMMIT_PEND]) pend_d = 1'b1;
  end

  // Commit-pending flag register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  assign rd_word = sh_q[widx];
  assign pend    = pend_q;
`else
  logic unused_rise;
  assign unused_rise = rise;

  // Live words take byte-masked writes directly.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NW; i++) live_q[i] <= '0;
    end else if (wr && hit) begin
      live_q[widx] <= be_merge(live_q[widx], AVL_WRITEDATA, AVL_BYTE_EN);
    end
  end

  assign rd_word = live_q[widx];
  assign pend    = 1'b0;
`endif

  // STATUS word assembled from live flags; unused bits read 0.
  always_comb begin
    status_w = '0;
    status_w[ST_VS_TOGGLE]                    = vs_tog;
    status_w[ST_COMMIT_PEND]                  = pend;
    status_w[ST_FRAME_CNT_LSB +: CNT_W]       = frame_cnt;
  end

  // Read mux; the result is held until the next read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      if (hit)        rdata_d = rd_word;
      else if (is_st) rdata_d = status_w;
      else            rdata_d = '0;
    end
  end

  // Registered read data.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign AVL_READDATA = rdata_q;
  assign ctrl_live    = live_q[CTRL_A];

  for (genvar p = 0; p < PAL_DEPTH; p++) begin : g_pal
    assign pal_live[32*p +: 32] = live_q[p];
  end
  for (genvar a = 0; a < ATTR_DEPTH; a++) begin : g_attr
    assign attr_live[32*a +: 32] = live_q[CTRL_A + 1 + a];
  end

endmodule

// File: tb/tb_vga_attr_regbank.sv
// Scoreboard bench for vga_attr_regbank: a bench-side model of shadow/live
// words, STATUS and frame count produces expected read data, which is queued
// at the read strobe and compared when AVL_READDATA is valid. Follows
// VGA_ATTR_SHADOW_EN the same way the design does. Uses CNT_W=4 so the
// frame counter wrap is reachable in a short run.
module tb_vga_attr_regbank;

  localparam int PD = 8, AD = 32, AW = 11, CW = 4;
  localparam int NW = PD + 1 + AD;
  localparam int A_CTRL = PD, A_ST = PD + 1, A_ATTR = PD + 2;

  logic CLK = 1'b0, RESET = 1'b0;
  logic AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0, vs = 1'b0;
  logic [AW-1:0] AVL_ADDR = '0;
  logic [3:0]    AVL_BYTE_EN = '0;
  logic [31:0]   AVL_WRITEDATA = '0;
  logic [31:0]   AVL_READDATA;
  logic [PD*32-1:0] pal_live;
  logic [31:0]      ctrl_live;
  logic [AD*32-1:0] attr_live;
  logic             frame_tick;

  int checks = 0, failures = 0;

  logic [31:0] m_sh [NW];
  logic [31:0] m_live [NW];
  logic        m_pend;
  int          m_rise;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] last_rd;

  vga_attr_regbank #(.PAL_DEPTH(PD), .ATTR_DEPTH(AD), .ADDR_W(AW), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA), .vs(vs),
    .pal_live(pal_live), .ctrl_live(ctrl_live), .attr_live(attr_live),
    .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic int widx(input int a);
    if (a >= 0 && a <= A_CTRL) return a;
    if (a >= A_ATTR && a < A_ATTR + AD) return a - 1;
    return -1;
  endfunction

  function automatic logic [31:0] mstatus();
    logic [31:0] s;
    s = '0;
    s[16 +: CW] = CW'(m_rise % 16);
    s[1] = m_pend;
    s[0] = (m_rise % 2) != 0;
    return s;
  endfunction

  function automatic logic [31:0] mread(input int a);
    int i;
    if (a == A_ST) return mstatus();
    i = widx(a);
    if (i < 0) return 32'h0;
`ifdef VGA_ATTR_SHADOW_EN
    return m_sh[i];
`else
    return m_live[i];
`endif
  endfunction

  function automatic logic [31:0] live_word(input int i);
    if (i < PD)  return pal_live[32*i +: 32];
    if (i == PD) return ctrl_live;
    return attr_live[32*(i-PD-1) +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic m_clear;
    for (int i = 0; i < NW; i++) begin m_sh[i] = '0; m_live[i] = '0; end
    m_pend = 1'b0;
    m_rise = 0;
  endtask

  task automatic m_rise_ev;
    m_rise++;
`ifdef VGA_ATTR_SHADOW_EN
    if (m_pend) begin
      for (int i = 0; i < NW; i++) m_live[i] = m_sh[i];
      m_pend = 1'b0;
    end
`endif
  endtask

  task automatic m_write(input int a, input logic [31:0] d, input logic [3:0] be);
    int i;
    i = widx(a);
`ifdef VGA_ATTR_SHADOW_EN
    if (a == A_ST && be[0] && d[1]) m_pend = 1'b1;
    if (i >= 0) m_sh[i] = merge(m_sh[i], d, be);
`else
    if (i >= 0) m_live[i] = merge(m_live[i], d, be);
`endif
  endtask

  task automatic avl_wr(input int a, input logic [31:0] d, input logic [3:0] be, input bit with_vs);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = AW'(a);
    AVL_WRITEDATA = d; AVL_BYTE_EN = be; vs = with_vs;
    tick;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; vs = 1'b0;
    if (with_vs) begin
      m_rise_ev();
      chk("wr_vs_frame_tick", 32'(frame_tick), 32'd1);
    end
    m_write(a, d, be);
    if (with_vs) tick;
  endtask

  // also_wr drives a simultaneous write, which the design must drop.
  task automatic avl_rd(input int a, input bit also_wr, input logic [31:0] d);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = also_wr; AVL_ADDR = AW'(a);
    AVL_WRITEDATA = d; AVL_BYTE_EN = 4'hF;
    exp_q.push_back(mread(a));
    tag_q.push_back($sformatf("rd_addr%0d", a));
    tick;
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    last_rd = exp_q.pop_front();
    chk(tag_q.pop_front(), AVL_READDATA, last_rd);
  endtask

  task automatic vs_pulse;
    vs = 1'b1;
    tick;
    m_rise_ev();
    chk("frame_tick_hi", 32'(frame_tick), 32'd1);
    vs = 1'b0;
    tick;
    chk("frame_tick_lo", 32'(frame_tick), 32'd0);
  endtask

  task automatic chk_live(input int i);
    chk($sformatf("live_w%0d", i), live_word(i), m_live[i]);
  endtask

  task automatic do_reset;
    RESET = 1'b0;
    m_clear();
    tick;
    tick;
    RESET = 1'b1;
    tick;
  endtask

  initial begin
    m_clear();
    do_reset();

    // Reset state
    chk("rst_frame_tick", 32'(frame_tick), 32'd0);
    chk("rst_readdata", AVL_READDATA, 32'd0);
    for (int i = 0; i < NW; i++) chk_live(i);
    avl_rd(0, 1'b0, '0);
    avl_rd(A_ST, 1'b0, '0);
    avl_rd(A_CTRL, 1'b0, '0);

    // Byte-masked palette write; live stays until committed (shadow build)
    avl_wr(3, 32'h00AB_CDEF, 4'b0101, 1'b0);
    chk_live(3);
    avl_rd(3, 1'b0, '0);
    tick;
    chk("rd_hold", AVL_READDATA, last_rd);
    vs_pulse();
    chk_live(3);
    avl_rd(A_ST, 1'b0, '0);

    // Arm without byte 0 enable does nothing
    avl_wr(A_ST, 32'h2, 4'b1110, 1'b0);
    avl_rd(A_ST, 1'b0, '0);

    // Arm in the same cycle as a rise: no commit yet
    avl_wr(A_ST, 32'h2, 4'hF, 1'b1);
    chk_live(3);
    avl_rd(A_ST, 1'b0, '0);
    vs_pulse();
    chk_live(3);
    avl_rd(A_ST, 1'b0, '0);

    // Shadow write in the commit cycle
    avl_wr(A_ATTR + 5, 32'h11, 4'hF, 1'b0);
    avl_wr(A_ST, 32'h2, 4'hF, 1'b0);
    avl_wr(A_ATTR + 5, 32'h22, 4'hF, 1'b1);
    chk_live(PD + 1 + 5);
    avl_rd(A_ATTR + 5, 1'b0, '0);
    avl_rd(A_ST, 1'b0, '0);

    // Unmapped addresses read 0 and ignore writes
    avl_wr(A_ATTR + AD - 1, 32'hCAFE_0031, 4'hF, 1'b0);
    avl_rd(A_ATTR + AD, 1'b0, '0);
    avl_rd(2047, 1'b0, '0);
    avl_wr(A_ATTR + AD, 32'hDEAD_BEEF, 4'hF, 1'b0);
    avl_wr(2047, 32'hDEAD_BEEF, 4'hF, 1'b0);
    avl_rd(A_ATTR + AD - 1, 1'b0, '0);
    avl_rd(0, 1'b0, '0);
    avl_wr(A_ST, 32'h2, 4'hF, 1'b0);
    vs_pulse();
    for (int i = 0; i < NW; i++) chk_live(i);

    // Control write, then read+write collision drops the write
    avl_wr(A_CTRL, 32'h5A, 4'hF, 1'b0);
    chk_live(A_CTRL);
    avl_rd(A_CTRL, 1'b1, 32'hFF);
    avl_rd(A_CTRL, 1'b0, '0);
    chk_live(A_CTRL);

    // Frame counter wraps; toggle back to 0 on an even count
    for (int k = 0; k < 40 && (m_rise % 16) != 0; k++) vs_pulse();
    avl_rd(A_ST, 1'b0, '0);
    vs_pulse();
    avl_rd(A_ST, 1'b0, '0);

    // Reset mid-frame drops a pending commit
    avl_wr(A_CTRL, 32'h77, 4'hF, 1'b0);
    avl_wr(A_ST, 32'h2, 4'hF, 1'b0);
    avl_rd(A_ST, 1'b0, '0);
    do_reset();
    avl_rd(A_ST, 1'b0, '0);
    chk_live(A_CTRL);
    vs_pulse();
    avl_rd(A_ST, 1'b0, '0);
    avl_rd(A_CTRL, 1'b0, '0);
    for (int i = 0; i < NW; i++) chk_live(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_attr_regbank.md
# vga_attr_regbank

Parametrised Avalon-MM register bank for the VGA subsystem. It holds the palette, one control word and a configurable array of game-attribute words. Writes land in shadow copies and are committed to the live copies atomically on the next vertical-sync rising edge once software arms a commit, so the renderer never sees a torn frame. It sits beside the VRAM port in the text/graphics display IP, in the AVL_ADDR[11]=1 half of the slave window, and feeds the colour mapper and motion engines.

## Interface
- PAL_DEPTH, 8: palette words.
- ATTR_DEPTH, 32: attribute words (game, coin, health, score, position, wall, bullet, tank regions are software-defined slices).
- ADDR_W, 11: word-address width of this bank.
- CNT_W, 16: frame-counter width; 1..16.
- CLK  in  1  system clock, 50 MHz; also VGA clock.
- RESET  in  1  asynchronous, active-low reset.
- AVL_CS, AVL_READ, AVL_WRITE  in  1 each  Avalon-MM slave strobes.
- AVL_ADDR  in  ADDR_W  word address within bank.
- AVL_BYTE_EN  in  4  byte enables.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  registered read data.
- vs  in  1  VGA vsync, synchronous to CLK.
- pal_live  out  PAL_DEPTH*32  live palette, word i at [32i+31:32i].
- ctrl_live  out  32  live control word.
- attr_live  out  ATTR_DEPTH*32  live attributes.
- frame_tick  out  1  one-cycle pulse on each vs rising edge.

## Operation
- Map: 0..PAL_DEPTH-1 palette; PAL_DEPTH control; PAL_DEPTH+1 STATUS; PAL_DEPTH+2 .. PAL_DEPTH+1+ATTR_DEPTH attributes; above is unmapped.
- Write (AVL_CS&AVL_WRITE): per-byte update of shadow word under AVL_BYTE_EN. Unmapped writes ignored.
- STATUS: bit0 VS_TOGGLE (flips each vs rise, RO); bit1 COMMIT_PEND (write 1 sets, write 0 no effect, cleared by commit); bits[15+CNT_W:16] FRAME_CNT (RO); others read 0. Byte 0 enable required to arm.
- Read (AVL_CS&AVL_READ): returns shadow for palette/control/attributes, STATUS live value, 0 for unmapped.
- vs edge detect: vs_q registered; rise = vs & ~vs_q. On rise: frame_tick=1, VS_TOGGLE flips, FRAME_CNT+1 mod 2^CNT_W; if COMMIT_PEND (pre-cycle value) then all live words <= shadow words and COMMIT_PEND cleared.
- Simultaneous arm and rise: commit uses old COMMIT_PEND; arm wins, so pending=1 after the cycle and commits on the next rise.
- Simultaneous shadow write and commit: live takes pre-write shadow; shadow takes new data.
- Read and write same cycle: write ignored, read serviced.

## Timing
- Reset: all shadow, live, STATUS, vs_q, frame_tick, AVL_READDATA = 0.
- Read latency 1: data valid on AVL_READDATA in cycle after strobe, held until next read.
- Write visible in shadow readback next cycle; in live outputs cycle after committing rise.
- frame_tick asserts in cycle rise is detected (one cycle after vs goes high).
- Reset mid-frame clears pending commit; first rise after reset only counts.

## Configuration
- VGA_ATTR_SHADOW_EN defined: behaviour above.
- Undefined: no shadow storage; writes update live words next cycle directly; reads return live; COMMIT_PEND reads 0 and write is ignored; VS_TOGGLE, FRAME_CNT, frame_tick unchanged.

## Structure
- Package vga_attr_pkg: STATUS bit positions, offset functions ctrl_addr(PAL_DEPTH), status_addr, attr_base, and byte-enable merge function.
- Sub-module vga_vs_edge: vs_q register, frame_tick, VS_TOGGLE and FRAME_CNT.

## Test plan
- Reset then read palette 0, STATUS -> 0x0000_0000 one cycle after each read strobe.
- Write palette 3 = 0x00ABCDEF BE=4'b0101, read back -> 0x00AB00EF; pal_live word 3 stays 0 until arm+vs rise, then 0x00AB00EF.
- Arm commit (STATUS=0x2) in same cycle as vs rise -> no commit, pending=1, FRAME_CNT=1; next rise commits, pending=0, FRAME_CNT=2.
- Write attr 5 in commit cycle with shadow 0x11, new 0x22 -> attr_live[5]=0x11, shadow reads 0x22.
- 65536 vs rises with CNT_W=16 -> FRAME_CNT wraps to 0, VS_TOGGLE=0; read unmapped address -> 0, write there changes nothing.
- Macro undefined: write control=0x5A -> ctrl_live=0x5A next cycle without vs; STATUS bit1 reads 0 after writing 0x2.
